recuperador_operando: RTL

// - Inverse of the mixed signed/unsigned adder stage: given the 8-bit sum and the first operand, recovers the second operand.
// - Recovery is B = soma - A, computed bit-serially, LSB first, one bit per clock.
// - Flags results that do not fit the declared width/signedness of B for the selected codigo.
// - Sits downstream of the adder in the arithmetic lab datapath.
// - Uses a valid/ready handshake on both sides.

---
 rtl/recuperador_operando.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/recuperador_operando.sv
// recuperador_operando
//   Recovers the second operand of the mixed signed/unsigned adder:
//   operando_b = soma - operando_a (mod 2^LARGURA), computed bit-serially,
//   LSB first, one bit per clock. The result is flagged when it does not fit
//   the declared width/signedness of B for the selected codigo.
//
//   Optional feature macro: RANGE_CHECK_EN
//     defined   -> fora_faixa computed per codigo
//     undefined -> range logic omitted, fora_faixa tied to 0
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     request handshake (in_ready=1 only in IDLE)
//   soma, operando_a        sum and known first operand
//   codigo                  operand-type code (same encoding as the adder)
//   out_valid / out_ready   result handshake (out_valid=1 only in DONE)
//   operando_b              recovered B, raw LARGURA-bit modular result
//   fora_faixa              B outside its declared range
module recuperador_operando #(
  parameter int LARGURA       = 8,
  parameter int LARGURA_CURTA = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LARGURA-1:0] soma,
  input  logic [LARGURA-1:0] operando_a,
  input  logic [1:0]         codigo,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LARGURA-1:0] operando_b,
  output logic               fora_faixa
);

  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               br_q, br_d;
  logic [LARGURA-1:0] s_q, s_d;     // shifted right each CALC edge; bit 0 is current bit
  logic [LARGURA-1:0] a_q, a_d;
  logic [LARGURA-1:0] res_q, res_d; // difference bits enter at the MSB
  logic [LARGURA-1:0] b_q, b_d;
  logic               fora_q, fora_d;
  logic               dif;

`ifdef RANGE_CHECK_EN
  logic [1:0] cod_q, cod_d;

  function automatic logic fora_calc(input logic [LARGURA-1:0] r, input logic [1:0] c);
    logic sfit;
    // Signed narrow fit: all bits from the narrow sign bit upward are equal.
    sfit = (&r[LARGURA-1:LARGURA_CURTA-1]) | ~(|r[LARGURA-1:LARGURA_CURTA-1]);
    case (c)
      2'b00, 2'b11: fora_calc = ~sfit;
      2'b01:        fora_calc = |r[LARGURA-1:LARGURA_CURTA];
      default:      fora_calc = 1'b0;
    endcase
  endfunction
`else
  logic unused_codigo;
  assign unused_codigo = &{1'b0, codigo};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      s_q     <= '0;
      a_q     <= '0;
      res_q   <= '0;
      b_q     <= '0;
      fora_q  <= 1'b0;
`ifdef RANGE_CHECK_EN
      cod_q   <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      s_q     <= s_d;
      a_q     <= a_d;
      res_q   <= res_d;
      b_q     <= b_d;
      fora_q  <= fora_d;
`ifdef RANGE_CHECK_EN
      cod_q   <= cod_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    s_d     = s_q;
    a_d     = a_q;
    res_d   = res_q;
    b_d     = b_q;
    fora_d  = fora_q;
    dif     = s_q[0] ^ a_q[0] ^ br_q;
`ifdef RANGE_CHECK_EN
    cod_d   = cod_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = soma;
          a_d     = operando_a;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef RANGE_CHECK_EN
          cod_d   = codigo;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        br_d  = (~s_q[0] & a_q[0]) | (~(s_q[0] ^ a_q[0]) & br_q);
        s_d   = s_q >> 1;
        a_d   = a_q >> 1;
        res_d = {dif, res_q[LARGURA-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LARGURA-1)) begin
          // Last bit: publish the full result on this edge; final borrow dropped.
          state_d = DONE;
          b_d     = res_d;
`ifdef RANGE_CHECK_EN
          fora_d  = fora_calc(res_d, cod_q);
`else
          fora_d  = 1'b0;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign operando_b = b_q;
  assign fora_faixa = fora_q;

endmodule
